audio_sample_pacer: RTL and testbench
=====================================

Name: audio_sample_pacer

Overview:
- Sits between the CPU memory-mapped audio write port and the PWM serializer.
- Buffers 10-bit duty-cycle samples written by software in a small FIFO.
- Releases one sample to the PWM serializer's duty_cycle input per fixed sample period, so playback timing no longer depends on instruction timing.
- Reports FIFO level and sticky overflow/underrun flags for a status readback register.

Parameters:
- WIDTH, 10, sample / duty-cycle width in bits.
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- SAMPLE_DIV, 1134, clock cycles per sample period (50 MHz / 1134 ≈ 44.09 kHz); must be at least 2.

Ports:
- clock  in  1  system clock (single clock domain).
- reset  in  1  synchronous reset, active-high.
- enable  in  1  playback enable; low freezes pacing.
- wr_en  in  1  one-cycle write strobe (CPU io write to the audio address).
- wr_data  in  WIDTH  sample to enqueue.
- clr_flags  in  1  one-cycle strobe; clears both sticky flags.
- duty_cycle  out  WIDTH  registered sample driving the PWM serializer.
- sample_tick  out  1  one-cycle pulse at each sample boundary.
- fifo_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  fifo_count == DEPTH.
- empty  out  1  fifo_count == 0.
- overflow  out  1  sticky: a write was dropped.
- underrun  out  1  sticky: a tick occurred while the FIFO was empty.

Behaviour:
- Reset, applied on the clock edge while reset=1, overrides everything:
  - read/write pointers, fifo_count and the divider are cleared to 0.
  - duty_cycle=0, sample_tick=0, overflow=0, underrun=0.
  - full=0, empty=1.
  - FIFO storage contents are don't-care.
  - Reset mid-playback discards all queued samples.
- Divider, counting 0..SAMPLE_DIV-1:
  - When enable=1, it increments each cycle and wraps to 0 after SAMPLE_DIV-1.
  - sample_tick is registered and is 1 in the cycle after the divider holds SAMPLE_DIV-1, i.e. once every SAMPLE_DIV cycles.
  - When enable=0, the divider is held at 0, no ticks are issued, and duty_cycle holds its value.
  - The first tick occurs SAMPLE_DIV cycles after enable rises.
- Pop, performed in the cycle sample_tick is internally generated:
  - If not empty, duty_cycle <= head entry and the read pointer advances. duty_cycle updates on the same edge sample_tick goes high.
  - If empty, duty_cycle holds its last value and underrun <= 1.
- Push, on wr_en=1:
  - Accepted if not full, or if a pop occurs in the same cycle. wr_data is written at the write pointer and the pointer advances.
  - Otherwise the write is dropped and overflow <= 1.
- Simultaneous push and pop:
  - fifo_count is unchanged.
  - When the FIFO is empty, the pop sees empty: underrun is set and the pushed value is stored, not bypassed to the output.
- Pointers wrap modulo DEPTH. fifo_count distinguishes full from empty; status outputs are registered and consistent with fifo_count.
- Flags:
  - overflow and underrun stay set until clr_flags or reset.
  - If clr_flags coincides with a new set event, the set event wins.
- Ordering: strict FIFO; samples leave in write order.

Test Plan (bench parameters DEPTH=4, SAMPLE_DIV=4):
- Reset then idle -> duty_cycle=0, empty=1, fifo_count=0, no ticks while enable=0, flags 0.
- Write 0x100, 0x200, 0x3FF with enable=0, then raise enable -> fifo_count=3. Ticks arrive 4, 8 and 12 cycles after enable rises, and duty_cycle steps 0x100, 0x200, 0x3FF. After the last pop empty=1.
- Write 5 samples (1,2,3,4,5) with enable=0 -> full=1 after the 4th write; the 5th is dropped and overflow=1. Pops then yield 1,2,3,4 only.
- Enable with the FIFO empty -> at the first tick duty_cycle holds its old value (0 after reset) and underrun=1. Pulse clr_flags -> underrun=0.
- FIFO full (4 entries), wr_en=1 with wr_data=9 on the tick cycle -> push accepted, fifo_count stays 4, no overflow. Last popped value is 9.
- Assert reset mid-playback with 2 entries queued -> next cycle fifo_count=0, duty_cycle=0, and no tick until SAMPLE_DIV cycles after reset is released.

Source files
------------

// File: rtl/audio_sample_pacer.sv
// audio_sample_pacer
//
// Buffers duty-cycle samples written by the CPU in a small FIFO and releases
// one sample per fixed sample period to the PWM serializer, so playback rate
// is set by the clock rather than by software timing.
//
// Parameters:
//   WIDTH      sample / duty-cycle width in bits
//   DEPTH      FIFO entries (power of two, >= 2)
//   SAMPLE_DIV clock cycles per sample period (>= 2)
//
// Ports:
//   clock        system clock
//   reset        synchronous reset, active-high
//   enable       playback enable; low holds the divider at 0 and stops ticks
//   wr_en        one-cycle write strobe
//   wr_data      sample to enqueue
//   clr_flags    one-cycle strobe clearing both sticky flags
//   duty_cycle   registered sample driving the PWM serializer
//   sample_tick  one-cycle pulse at each sample boundary
//   fifo_count   current occupancy, 0..DEPTH
//   full         fifo_count == DEPTH
//   empty        fifo_count == 0
//   overflow     sticky: a write was dropped
//   underrun     sticky: a tick occurred while the FIFO was empty
module audio_sample_pacer #(
    parameter int WIDTH      = 10,
    parameter int DEPTH      = 16,
    parameter int SAMPLE_DIV = 1134
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       clr_flags,
    output logic [WIDTH-1:0]           duty_cycle,
    output logic                       sample_tick,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underrun
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int DIVW = $clog2(SAMPLE_DIV);

    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [DIVW-1:0]  div;
    logic [CW-1:0]    count_nxt;

    logic tick_p0;
    logic do_pop;
    logic do_push;
    logic ovf_set;
    logic udr_set;

    // Stage 0: tick decision and FIFO handshakes (combinational)
    // A push into a full FIFO is still accepted when the same cycle pops,
    // because the pop frees the slot the push needs.
    always_comb begin
        tick_p0 = enable && (div == DIV_LAST);
        do_pop  = tick_p0 && !empty;
        do_push = wr_en && (!full || do_pop);
        ovf_set = wr_en && !do_push;
        udr_set = tick_p0 && empty;

        count_nxt = fifo_count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = fifo_count + CW'(1);
            2'b01:   count_nxt = fifo_count - CW'(1);
            default: count_nxt = fifo_count;
        endcase
    end

    // Sample storage is not reset; its contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Stage 1: registered outputs, pointers, divider and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            div         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            duty_cycle  <= '0;
            sample_tick <= 1'b0;
            overflow    <= 1'b0;
            underrun    <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            if (!enable || tick_p0) begin
                div <= '0;
            end else begin
                div <= div + DIVW'(1);
            end

            sample_tick <= tick_p0;

            if (do_pop) begin
                duty_cycle <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + AW'(1);
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            fifo_count <= count_nxt;
            full       <= (count_nxt == FULL_CNT);
            empty      <= (count_nxt == '0);

            // A new set event takes priority over a coincident clear.
            overflow <= ovf_set || (overflow && !clr_flags);
            underrun <= udr_set || (underrun && !clr_flags);
        end
    end

endmodule

// File: tb/tb_audio_sample_pacer.sv
module tb_audio_sample_pacer;

    localparam int WIDTH      = 10;
    localparam int DEPTH      = 4;
    localparam int SAMPLE_DIV = 4;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clr_flags;
    logic [WIDTH-1:0] duty_cycle;
    logic             sample_tick;
    logic [2:0]       fifo_count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underrun;

    audio_sample_pacer #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr_flags   (clr_flags),
        .duty_cycle  (duty_cycle),
        .sample_tick (sample_tick),
        .fifo_count  (fifo_count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .underrun    (underrun)
    );

    typedef struct {
        logic [WIDTH-1:0] duty;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Monitor: every observed tick must match the next expected tick, both in
    // the duty_cycle value it presents and in the cycle it arrives.
    always @(negedge clock) begin
        if (sample_tick) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_tick: tick at cycle %0d with duty=%h, none expected", cyc, duty_cycle);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (duty_cycle !== e.duty || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL tick: got duty=%h at cycle %0d, expected duty=%h at cycle %0d",
                             duty_cycle, cyc, e.duty, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write(input logic [WIDTH-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic expect_tick(input logic [WIDTH-1:0] d, input int c);
        exp_t e;
        e.duty = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    // Enable for exactly n sample periods; tick k lands SAMPLE_DIV*k cycles
    // after enable rises.
    task automatic play(input int n);
        enable = 1'b1;
        repeat (n * SAMPLE_DIV) step();
        enable = 1'b0;
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        enable    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        clr_flags = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state and idle with enable low: no ticks expected.
        repeat (10) step();
        chk("reset_duty",     duty_cycle, 0);
        chk("reset_empty",    empty,      1);
        chk("reset_full",     full,       0);
        chk("reset_count",    fifo_count, 0);
        chk("reset_overflow", overflow,   0);
        chk("reset_underrun", underrun,   0);

        // Underrun: enable with an empty FIFO, duty holds 0.
        base = cyc;
        expect_tick(10'h000, base + 4);
        play(1);
        chk("udr_flag", underrun,   1);
        chk("udr_duty", duty_cycle, 0);
        pulse_clr();
        chk("udr_clear", underrun, 0);

        // Three samples played in order.
        write(10'h100);
        write(10'h200);
        write(10'h3FF);
        chk("three_count", fifo_count, 3);
        base = cyc;
        expect_tick(10'h100, base + 4);
        expect_tick(10'h200, base + 8);
        expect_tick(10'h3FF, base + 12);
        play(3);
        chk("three_empty", empty,      1);
        chk("three_count0", fifo_count, 0);
        chk("three_udr",   underrun,   0);

        // Overflow: fifth write dropped.
        for (int i = 1; i <= 4; i++) write(WIDTH'(i));
        chk("ovf_full",  full,       1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag0", overflow,   0);
        write(10'd5);
        chk("ovf_flag",  overflow,   1);
        chk("ovf_count4", fifo_count, 4);
        base = cyc;
        for (int i = 1; i <= 4; i++) expect_tick(WIDTH'(i), base + 4 * i);
        play(4);
        chk("ovf_empty", empty, 1);
        chk("ovf_udr",   underrun, 0);
        pulse_clr();
        chk("ovf_clear", overflow, 0);

        // Full FIFO, push on the tick cycle is accepted.
        for (int i = 5; i <= 8; i++) write(WIDTH'(i));
        chk("tickpush_full", full, 1);
        base = cyc;
        for (int i = 1; i <= 5; i++) expect_tick(WIDTH'(i + 4), base + 4 * i);
        enable = 1'b1;
        repeat (SAMPLE_DIV - 1) step();
        wr_en   = 1'b1;
        wr_data = 10'd9;
        step();
        wr_en   = 1'b0;
        chk("tickpush_count", fifo_count, 4);
        chk("tickpush_ovf",   overflow,   0);
        chk("tickpush_full1", full,       1);
        repeat (4 * SAMPLE_DIV) step();
        enable = 1'b0;
        chk("tickpush_last",  duty_cycle, 9);
        chk("tickpush_empty", empty,      1);
        chk("tickpush_ovf2",  overflow,   0);

        // Reset mid-playback discards queued samples and restarts pacing.
        write(10'h011);
        write(10'h022);
        chk("mid_count2", fifo_count, 2);
        enable = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_count", fifo_count, 0);
        chk("mid_duty",  duty_cycle, 0);
        chk("mid_empty", empty,      1);
        chk("mid_tick",  sample_tick, 0);
        reset = 1'b0;
        base = cyc;
        expect_tick(10'h000, base + 4);
        repeat (SAMPLE_DIV) step();
        enable = 1'b0;
        chk("mid_udr", underrun, 1);

        // Let the monitor observe the last tick, then confirm nothing is left.
        repeat (4) step();
        chk("ticks_remaining", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
